// File: rtl/game_timer.sv
// rtl/game_timer.sv - elapsed game time in three BCD digits with run/pause/stop control
module game_timer #(
    parameter int CLK_FREQ = 25_000_000,
    parameter int PRESC_W  = $clog2(CLK_FREQ)
) (
    input  logic       vga_clk,
    input  logic       sys_rst,
    input  logic       game_start,
    input  logic       game_pause,
    input  logic       game_over,
    output logic [3:0] time_1s,
    output logic [3:0] time_10s,
    output logic [3:0] time_100s,
    output logic       tick_1s,
    output logic       timer_run,
    output logic       time_max
);

    // A CLK_FREQ of 1 would give a zero-width prescaler; keep at least one bit.
    localparam int            PW         = (PRESC_W < 1) ? 1 : PRESC_W;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_FREQ - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSED  = 2'd2,
        STOPPED = 2'd3
    } state_t;

    state_t        state, state_n;
    logic [PW-1:0] presc, presc_n;
    logic [3:0]    d1_n, d10_n, d100_n;
    logic          tick_n, run_n, max_n;

    logic wrap, at_max, count_en, restart, sec_inc, saturate;

    assign wrap     = (presc == PRESC_LAST);
    assign at_max   = (time_1s == 4'd9) && (time_10s == 4'd9) && (time_100s == 4'd9);
    assign count_en = (state == RUN) && !game_over && !game_pause;
    assign restart  = ((state == IDLE) || (state == STOPPED)) && game_start && !game_over;
    assign sec_inc  = count_en && wrap && !at_max;
    assign saturate = count_en && wrap && at_max;

    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (restart) state_n = RUN;
            end
            RUN: begin
                if (game_over)       state_n = STOPPED;
                else if (game_pause) state_n = PAUSED;
                else if (saturate)   state_n = STOPPED;
            end
            PAUSED: begin
                if (game_over)       state_n = STOPPED;
                else if (!game_pause) state_n = RUN;
            end
            STOPPED: begin
                if (restart) state_n = RUN;
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        presc_n = presc;
        d1_n    = time_1s;
        d10_n   = time_10s;
        d100_n  = time_100s;
        tick_n  = sec_inc;
        run_n   = (state_n == RUN);
        max_n   = time_max;

        if (restart) begin
            presc_n = '0;
            d1_n    = 4'd0;
            d10_n   = 4'd0;
            d100_n  = 4'd0;
            max_n   = 1'b0;
        end else if (count_en) begin
            presc_n = wrap ? '0 : presc + 1'b1;
            if (saturate) begin
                max_n = 1'b1;
            end else if (sec_inc) begin
                // Ripple carry through the BCD digits; 999 never reaches here.
                if (time_1s == 4'd9) begin
                    d1_n = 4'd0;
                    if (time_10s == 4'd9) begin
                        d10_n  = 4'd0;
                        d100_n = time_100s + 4'd1;
                    end else begin
                        d10_n = time_10s + 4'd1;
                    end
                end else begin
                    d1_n = time_1s + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            presc     <= '0;
            time_1s   <= 4'd0;
            time_10s  <= 4'd0;
            time_100s <= 4'd0;
            tick_1s   <= 1'b0;
            timer_run <= 1'b0;
            time_max  <= 1'b0;
        end else begin
            presc     <= presc_n;
            time_1s   <= d1_n;
            time_10s  <= d10_n;
            time_100s <= d100_n;
            tick_1s   <= tick_n;
            timer_run <= run_n;
            time_max  <= max_n;
        end
    end

endmodule

// File: doc/game_timer.md
Name: game_timer

Overview:
- Elapsed-game-time counter feeding the border/HUD renderer's time_1s, time_10s and time_100s digit inputs.
- Divides vga_clk down to a 1 s tick and counts seconds in three BCD digits (000–999).
- A small run-control FSM gives start, pause, game-over and saturation behaviour.
- Sits between the game-control logic (start/pause/over strobes) and the HUD drawing stage.

Parameters:
- CLK_FREQ, 25_000_000: vga_clk cycles per second; the prescaler wraps at CLK_FREQ-1. Benches override it to a small value (e.g. 4).
- PRESC_W, $clog2(CLK_FREQ): prescaler width; derived, not overridden.

Ports:
- vga_clk  input  1  pixel clock; the only clock.
- sys_rst  input  1  synchronous, active-high reset.
- game_start  input  1  one-cycle strobe: clear time and begin counting.
- game_pause  input  1  level: hold time while high.
- game_over  input  1  one-cycle strobe: freeze time.
- time_1s  output  4  BCD units digit, 0–9.
- time_10s  output  4  BCD tens digit, 0–9.
- time_100s  output  4  BCD hundreds digit, 0–9.
- tick_1s  output  1  one-cycle pulse on each second increment.
- timer_run  output  1  high while the FSM is in RUN.
- time_max  output  1  high once the count has saturated at 999.

Behaviour:
- All state is updated on the vga_clk rising edge; all outputs are registered.
- Reset (sys_rst=1, sampled on an edge):
  - state=IDLE, prescaler=0, all digits=0, tick_1s=0, timer_run=0, time_max=0.
  - Applies from any state, including mid-count; it overrides all other inputs that cycle.
- FSM states: IDLE, RUN, PAUSED, STOPPED. Input priority each cycle: sys_rst > game_over > game_start > game_pause.
- IDLE:
  - game_start → RUN; digits, prescaler and time_max cleared.
  - game_over is ignored and the FSM stays in IDLE.
- RUN:
  - game_over → STOPPED.
  - else game_pause=1 → PAUSED.
  - else count.
  - game_start is ignored.
- PAUSED:
  - game_over → STOPPED.
  - game_pause=0 → RUN.
  - The prescaler holds its value (it is not cleared), so a partial second resumes where it left off.
  - game_start is ignored.
- STOPPED:
  - Digits are frozen.
  - game_start → RUN with digits, prescaler and time_max cleared.
  - game_start together with game_over → stay in STOPPED (game_over wins).
- Counting (RUN only, and only in cycles with no transition out of RUN):
  - The prescaler increments each cycle.
  - At prescaler==CLK_FREQ-1: prescaler←0, BCD increments by 1, and tick_1s=1 in the following cycle, coincident with the new digit values.
- Latency: game_start sampled at edge k → timer_run=1 after edge k. The first increment is visible after edge k+CLK_FREQ, assuming no pause.
- BCD rules:
  - units 9→0 carries into tens; tens 9→0 carries into hundreds.
  - Digits never take values 10–15.
- Saturation: when the increment would take 999 past 999:
  - digits stay at 999;
  - time_max←1;
  - state←STOPPED;
  - no tick_1s pulse.
- The transition 998→999 is a normal increment and does pulse tick_1s.
- Simultaneous events: a game_over or game_pause in the same cycle the prescaler wraps suppresses that increment. The prescaler holds at CLK_FREQ-1 while PAUSED, so the increment happens on the first RUN cycle after resume.
- timer_run = (state==RUN). time_max is cleared only by reset or a restart via game_start.

Test Plan:
- Reset and start, CLK_FREQ=4: assert sys_rst 2 cycles → digits 0, timer_run 0. Pulse game_start → timer_run=1 next cycle; after 4 RUN cycles time_1s=1 with a single tick_1s pulse; after 40 cycles the digits read 010 (tens carry).
- Pause mid-second, CLK_FREQ=4: run 2 cycles, hold game_pause 10 cycles → digits unchanged, no tick. Release → next increment after 2 more RUN cycles.
- Saturation: run until 999 is reached → next wrap leaves 999, time_max=1, timer_run=0, no tick. A further game_start → 000, time_max=0, RUN.
- game_over at value 037 → frozen at 037 for 100 cycles. game_start and game_over pulsed in the same cycle → still STOPPED at 037.
- Reset mid-count at 512 with game_pause high → next cycle all outputs zero, state IDLE. game_over strobe in IDLE → no change.
- Wrap-cycle collision: pulse game_over on the cycle the prescaler equals CLK_FREQ-1 → no increment, no tick_1s, STOPPED.
